// File: rtl/enc_4x2_rr.sv
// Sequential round-robin encoder: collects one-hot request events into a sticky
// pending register and issues their indices one at a time on a valid/ready handshake.
module enc_4x2_rr #(
   parameter int N = 4,
   parameter int W = 2
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         e,
   input  logic         flush,
   input  logic [N-1:0] i,
   output logic [W-1:0] o,
   output logic         o_valid,
   input  logic         o_ready,
   output logic [N-1:0] pend,
   output logic         any,
   output logic         ovf
);

   // state   | meaning
   // IDLE    | no index presented; grants from pend when non-empty
   // PRESENT | o/o_valid held until the consumer accepts
   typedef enum logic {IDLE, PRESENT} state_t;

   state_t       state_q;
   logic [W-1:0] o_q;
   logic         o_valid_q;
   logic [N-1:0] pend_q, pend_d;
   logic         ovf_q, ovf_d;
   logic [W-1:0] ptr_q;

   logic [N-1:0] clr;
   logic [N-1:0] arr;
   logic [W-1:0] win;
   logic [W-1:0] idx;
   logic         found;

   assign clr = (state_q == PRESENT && o_ready) ? (N'(1) << o_q) : '0;
   assign arr = e ? i : '0;

   // A bit being cleared while it re-arrives is a fresh event, not an overrun.
   assign pend_d = (pend_q & ~clr) | arr;
   assign ovf_d  = ovf_q | (|(arr & pend_q & ~clr));

   // First set bit of the registered pend searching upward from ptr, wrapping.
   always_comb begin
      win   = '0;
      idx   = '0;
      found = 1'b0;
      for (int k = 0; k < N; k++) begin
         idx = ptr_q + W'(k);
         if (!found && pend_q[idx]) begin
            win   = idx;
            found = 1'b1;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= IDLE;
         o_q       <= '0;
         o_valid_q <= 1'b0;
         pend_q    <= '0;
         ovf_q     <= 1'b0;
         ptr_q     <= '0;
      end else if (flush) begin
         state_q   <= IDLE;
         o_valid_q <= 1'b0;
         pend_q    <= '0;
         ovf_q     <= 1'b0;
         ptr_q     <= '0;
      end else begin
         pend_q <= pend_d;
         ovf_q  <= ovf_d;
         case (state_q)
            IDLE: begin
               if (found) begin
                  o_q       <= win;
                  o_valid_q <= 1'b1;
                  state_q   <= PRESENT;
               end
            end
            PRESENT: begin
               if (o_ready) begin
                  o_valid_q <= 1'b0;
                  ptr_q     <= o_q + W'(1);
                  state_q   <= IDLE;
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign o       = o_q;
   assign o_valid = o_valid_q;
   assign pend    = pend_q;
   assign any     = |pend_q;
   assign ovf     = ovf_q;

endmodule

// File: tb/tb_enc_4x2_rr.sv
// Bench for enc_4x2_rr: directed scenarios plus random traffic, every cycle
// compared against an integer-level model of the pending set and round-robin grant.
module tb_enc_4x2_rr;

   localparam int N = 4;
   localparam int W = 2;

   logic         clk = 1'b0;
   logic         rst_n;
   logic         e, flush, o_ready;
   logic [N-1:0] i;
   logic [W-1:0] o;
   logic         o_valid;
   logic [N-1:0] pend;
   logic         any;
   logic         ovf;

   int n_vec = 0;
   int n_err = 0;

   int m_pend, m_o, m_v, m_ovf, m_ptr;

   enc_4x2_rr #(.N(N), .W(W)) dut (
      .clk(clk), .rst_n(rst_n), .e(e), .flush(flush), .i(i),
      .o(o), .o_valid(o_valid), .o_ready(o_ready),
      .pend(pend), .any(any), .ovf(ovf)
   );

   always #5 clk = ~clk;

   task automatic check_val(input string tag, input int act, input int exp);
      n_vec++;
      if (act != exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d at %0t", tag, act, exp, $time);
      end
   endtask

   task automatic model_reset();
      m_pend = 0; m_o = 0; m_v = 0; m_ovf = 0; m_ptr = 0;
   endtask

   // Pending set as an integer bitmask; grant is the first pending index at or after ptr mod N.
   task automatic model_edge(input int ee, input int fl, input int rdy, input int ii);
      int clr, arr, old_pend;
      if (fl != 0) begin
         m_pend = 0; m_v = 0; m_ovf = 0; m_ptr = 0;
         return;
      end
      old_pend = m_pend;
      clr = (m_v != 0 && rdy != 0) ? (1 << m_o) : 0;
      arr = (ee != 0) ? ii : 0;
      if ((arr & old_pend & ~clr) != 0) m_ovf = 1;
      m_pend = (old_pend & ~clr) | arr;
      if (m_v == 0) begin
         for (int k = 0; k < N; k++) begin
            if ((old_pend >> ((m_ptr + k) % N)) & 1) begin
               m_o = (m_ptr + k) % N;
               m_v = 1;
               break;
            end
         end
      end else if (rdy != 0) begin
         m_v = 0;
         m_ptr = (m_o + 1) % N;
      end
   endtask

   task automatic compare_all();
      check_val("o", int'(o), m_o);
      check_val("o_valid", int'(o_valid), m_v);
      check_val("pend", int'(pend), m_pend);
      check_val("any", int'(any), (m_pend != 0) ? 1 : 0);
      check_val("ovf", int'(ovf), m_ovf);
   endtask

   task automatic step(input logic ee, input logic fl, input logic rdy, input logic [N-1:0] ii);
      e = ee; flush = fl; o_ready = rdy; i = ii;
      @(posedge clk);
      model_edge(int'(ee), int'(fl), int'(rdy), int'(ii));
      @(negedge clk);
      compare_all();
   endtask

   initial begin
      rst_n = 1'b0; e = 1'b0; flush = 1'b0; o_ready = 1'b0; i = '0;
      model_reset();
      repeat (2) @(negedge clk);
      compare_all();
      rst_n = 1'b1;

      // single request
      step(1, 0, 1, 4'b0100);
      check_val("single_pend", int'(pend), 4);
      step(0, 0, 1, 4'b0000);
      check_val("single_o", int'(o), 2);
      step(0, 0, 1, 4'b0000);
      check_val("single_drain", int'(o_valid), 0);

      // round robin: 0011 then 1001
      step(1, 0, 1, 4'b0011);
      step(0, 0, 1, 4'b0000);
      check_val("rr_first", int'(o), 0);
      repeat (2) step(0, 0, 1, 4'b0000);
      check_val("rr_second", int'(o), 1);
      step(0, 0, 1, 4'b0000);
      step(1, 0, 1, 4'b1001);
      step(0, 0, 1, 4'b0000);
      check_val("rr_wrap_a", int'(o), 3);
      repeat (2) step(0, 0, 1, 4'b0000);
      check_val("rr_wrap_b", int'(o), 0);
      step(0, 0, 1, 4'b0000);

      // backpressure with o=1
      step(1, 0, 0, 4'b0010);
      step(0, 0, 0, 4'b0000);
      step(1, 0, 0, 4'b0001);
      repeat (4) step(0, 0, 0, 4'b0000);
      check_val("bp_hold_o", int'(o), 1);
      check_val("bp_pend", int'(pend), 3);
      step(0, 0, 1, 4'b0000);
      step(0, 0, 1, 4'b0000);
      check_val("bp_next", int'(o), 0);
      step(0, 0, 1, 4'b0000);

      // asynchronous reset while presenting, ptr currently 1
      step(1, 0, 0, 4'b0110);
      step(0, 0, 0, 4'b0000);
      #2 rst_n = 1'b0;
      #1;
      model_reset();
      compare_all();
      #1 rst_n = 1'b1;
      step(1, 0, 1, 4'b1001);
      step(0, 0, 1, 4'b0000);
      check_val("post_rst_grant", int'(o), 0);
      repeat (4) step(0, 0, 1, 4'b0000);

      // gating, overrun, flush
      step(1, 0, 0, 4'b0001);
      step(0, 0, 0, 4'b1111);
      step(1, 0, 0, 4'b1000);
      step(1, 0, 0, 4'b1000);
      check_val("ovr_set", int'(ovf), 1);
      step(0, 1, 0, 4'b0100);
      check_val("flush_pend", int'(pend), 0);

      // clear/arrival collision on bit 1
      step(1, 0, 0, 4'b0010);
      step(0, 0, 0, 4'b0000);
      step(1, 0, 1, 4'b0010);
      check_val("coll_pend", int'(pend), 2);
      check_val("coll_ovf", int'(ovf), 0);
      step(0, 0, 0, 4'b0000);
      check_val("coll_reissue", int'(o), 1);
      step(0, 0, 1, 4'b0000);

      // random traffic
      for (int n = 0; n < 400; n++) begin
         step(logic'($urandom_range(0, 3) != 0),
              logic'($urandom_range(0, 39) == 0),
              logic'($urandom_range(0, 2) != 0),
              ($urandom_range(0, 2) == 0) ? 4'($urandom) : 4'b0000);
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
